lfsr_sng: RTL and testbench

Parametrised, multi-channel stochastic number generator built around a Fibonacci LFSR with a configurable tap mask. On `start` it runs exactly one full LFSR period (2^WIDTH−1 cycles). Each cycle it emits one stochastic bit per channel by comparing a rotated view of the LFSR state against that channel's threshold. It sits in front of the stochastic-computing arithmetic units as their bitstream source. It adds runtime seeding, stalling, lock-up protection and a start/busy/done handshake on top of the fixed 8-bit LFSR.

---
 rtl/lfsr_sng_if.sv | 28 ++
 rtl/lfsr_sng.sv | 113 +++++++++++
 tb/tb_lfsr_sng.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_sng_if.sv
// Handshake/data bundle for the LFSR stochastic number generator.
// The master drives control and thresholds. The slave (generator) returns status and bitstreams.
interface lfsr_sng_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2
);
   logic                      seed_load;
   logic [WIDTH-1:0]          seed_in;
   logic                      start;
   logic                      en;
   logic [CHANNELS*WIDTH-1:0] threshold;
   logic                      busy;
   logic                      sn_valid;
   logic [CHANNELS-1:0]       sn_bit;
   logic                      done;
   logic                      lockup;
   logic [WIDTH-1:0]          lfsr_out;

   modport master (
      output seed_load, seed_in, start, en, threshold,
      input  busy, sn_valid, sn_bit, done, lockup, lfsr_out
   );

   modport slave (
      input  seed_load, seed_in, start, en, threshold,
      output busy, sn_valid, sn_bit, done, lockup, lfsr_out
   );
endinterface

// File: rtl/lfsr_sng.sv
// Multi-channel stochastic bitstream source: one full Fibonacci LFSR period per start.
// Outputs are registered, one cycle behind the state they reflect; en=0 stalls the run with no loss.
module lfsr_sng #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
   parameter logic [WIDTH-1:0] SEED     = 8'hFF,
   parameter int               CHANNELS = 2,
   parameter int               ROT_STEP = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   lfsr_sng_if.slave   bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] LAST_CNT = {{(WIDTH-1){1'b1}}, 1'b0};

   state_t                    state_q, state_d;
   logic [WIDTH-1:0]          lfsr_q, lfsr_d;
   logic [WIDTH-1:0]          cnt_q, cnt_d;
   logic [CHANNELS*WIDTH-1:0] thr_q, thr_d;
   logic [CHANNELS-1:0]       sn_bit_q, sn_bit_d;
   logic                      sn_valid_q, sn_valid_d;
   logic                      done_q, done_d;
   logic                      lockup_q, lockup_d;
   logic [CHANNELS-1:0]       cmp;
   logic [WIDTH-1:0]          lfsr_nxt;

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] s, input int r);
      logic [2*WIDTH-1:0] dbl;
      dbl = {s, s} << r;
      return dbl[2*WIDTH-1 -: WIDTH];
   endfunction

   assign lfsr_nxt = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

   always_comb begin
      cmp = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         cmp[k] = rotl(lfsr_q, (k * ROT_STEP) % WIDTH) <= thr_q[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      cnt_d      = cnt_q;
      thr_d      = thr_q;
      sn_bit_d   = sn_bit_q;
      sn_valid_d = 1'b0;
      done_d     = 1'b0;
      lockup_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // A zero seed would lock the LFSR at zero forever, so substitute SEED.
            if (bus.seed_load) begin
               if (bus.seed_in == '0) begin
                  lfsr_d   = SEED;
                  lockup_d = 1'b1;
               end else begin
                  lfsr_d = bus.seed_in;
               end
            end else if (bus.start) begin
               thr_d   = bus.threshold;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.en) begin
               sn_bit_d   = cmp;
               sn_valid_d = 1'b1;
               lfsr_d     = lfsr_nxt;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         lfsr_q     <= SEED;
         cnt_q      <= '0;
         thr_q      <= '0;
         sn_bit_q   <= '0;
         sn_valid_q <= 1'b0;
         done_q     <= 1'b0;
         lockup_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         cnt_q      <= cnt_d;
         thr_q      <= thr_d;
         sn_bit_q   <= sn_bit_d;
         sn_valid_q <= sn_valid_d;
         done_q     <= done_d;
         lockup_q   <= lockup_d;
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.sn_valid = sn_valid_q;
   assign bus.sn_bit   = sn_bit_q;
   assign bus.done     = done_q;
   assign bus.lockup   = lockup_q;
   assign bus.lfsr_out = lfsr_q;
endmodule

// File: tb/tb_lfsr_sng.sv
// Directed bench for lfsr_sng: default 8-bit/2-channel instance plus a 4-bit/3-channel instance.
module tb_lfsr_sng;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lfsr_sng_if #(.WIDTH(8), .CHANNELS(2)) b8 ();
   lfsr_sng_if #(.WIDTH(4), .CHANNELS(3)) b4 ();

   lfsr_sng u8 (.clk_i(clk), .rst_ni(rst_n), .bus(b8.slave));
   lfsr_sng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .CHANNELS(3), .ROT_STEP(3))
      u4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4.slave));

   int n_checks = 0;
   int n_fail   = 0;
   int nvalid, ones0, ones1, ones2, done_at, bad, cycles, dones;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one run of the 8-bit instance until done or budget expiry.
   task automatic run8(input bit sparse, input bit poke, output int nv, output int o0,
                       output int o1, output int dat, output int nbad, output int ncyc);
      nv = 0; o0 = 0; o1 = 0; dat = -1; nbad = 0; ncyc = 0;
      for (int i = 0; i < 2000; i++) begin
         b8.en = sparse ? (i % 3 == 0) : 1'b1;
         if (poke && i == 30) begin
            b8.start = 1'b1; b8.seed_load = 1'b1; b8.seed_in = 8'h33;
         end else begin
            b8.start = 1'b0; b8.seed_load = 1'b0;
         end
         tick;
         ncyc++;
         if (b8.sn_valid) begin
            nv++;
            o0 += int'(b8.sn_bit[0]);
            o1 += int'(b8.sn_bit[1]);
         end
         if (b8.sn_valid != b8.en) nbad++;
         if (b8.done) begin
            dat = nv;
            break;
         end
      end
      b8.en = 1'b1; b8.start = 1'b0; b8.seed_load = 1'b0;
   endtask

   initial begin
      b8.seed_load = 0; b8.seed_in = '0; b8.start = 0; b8.en = 1; b8.threshold = '0;
      b4.seed_load = 0; b4.seed_in = '0; b4.start = 0; b4.en = 1; b4.threshold = '0;
      #12;
      check("rst_lfsr", 32'(b8.lfsr_out), 32'hFF);
      check("rst_busy", 32'(b8.busy), 0);
      check("rst_valid", 32'(b8.sn_valid), 0);
      check("rst_snbit", 32'(b8.sn_bit), 0);
      check("rst_done", 32'(b8.done), 0);
      check("rst_lockup", 32'(b8.lockup), 0);
      check("rst_lfsr4", 32'(b4.lfsr_out), 32'h1);
      @(negedge clk) rst_n = 1'b1;

      // Run 1: thr0=128, thr1=0; thresholds changed after start must be ignored.
      b8.threshold = {8'd0, 8'd128};
      b8.start = 1'b1;
      tick;
      check("start_busy", 32'(b8.busy), 1);
      check("start_novalid", 32'(b8.sn_valid), 0);
      b8.threshold = '1;
      run8(1'b0, 1'b0, nvalid, ones0, ones1, done_at, bad, cycles);
      check("r1_nvalid", nvalid, 255);
      check("r1_cycles", cycles, 255);
      check("r1_ones0", ones0, 128);
      check("r1_ones1", ones1, 0);
      check("r1_done_at", done_at, 255);
      check("r1_busy_at_done", 32'(b8.busy), 0);
      check("r1_lfsr", 32'(b8.lfsr_out), 32'hFF);
      tick;
      check("r1_done_pulse", 32'(b8.done), 0);

      // Seed loading and lock-up substitution.
      b8.seed_load = 1'b1; b8.seed_in = 8'h00;
      tick;
      check("zseed_lfsr", 32'(b8.lfsr_out), 32'hFF);
      check("zseed_lockup", 32'(b8.lockup), 1);
      b8.seed_load = 1'b0;
      tick;
      check("lockup_pulse", 32'(b8.lockup), 0);
      b8.seed_load = 1'b1; b8.seed_in = 8'h01;
      tick;
      check("seed01_lfsr", 32'(b8.lfsr_out), 32'h01);
      check("seed01_lockup", 32'(b8.lockup), 0);
      b8.seed_load = 1'b1; b8.seed_in = 8'h5A; b8.start = 1'b1;
      tick;
      check("seed_vs_start_lfsr", 32'(b8.lfsr_out), 32'h5A);
      check("seed_vs_start_busy", 32'(b8.busy), 0);
      b8.seed_load = 1'b0; b8.start = 1'b0;
      tick;
      check("seed_vs_start_idle", 32'(b8.busy), 0);

      // Run 2: sparse enable, start/seed_load poked mid-run.
      b8.threshold = {8'd0, 8'd255};
      b8.start = 1'b1;
      tick;
      run8(1'b1, 1'b1, nvalid, ones0, ones1, done_at, bad, cycles);
      check("r2_nvalid", nvalid, 255);
      check("r2_ones0", ones0, 255);
      check("r2_ones1", ones1, 0);
      check("r2_valid_vs_en", bad, 0);
      check("r2_done_at", done_at, 255);
      check("r2_lfsr", 32'(b8.lfsr_out), 32'h5A);

      // Asynchronous reset at run cycle 100.
      b8.threshold = {8'd255, 8'd64};
      b8.start = 1'b1;
      tick;
      b8.start = 1'b0;
      dones = 0;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (b8.done) dones++;
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(b8.busy), 0);
      check("mid_rst_valid", 32'(b8.sn_valid), 0);
      check("mid_rst_snbit", 32'(b8.sn_bit), 0);
      check("mid_rst_done", 32'(b8.done), 0);
      check("mid_rst_lfsr", 32'(b8.lfsr_out), 32'hFF);
      check("pre_rst_no_done", dones, 0);
      @(negedge clk) rst_n = 1'b1;

      // Fresh run after reset, then a back-to-back start in the done cycle.
      b8.start = 1'b1;
      tick;
      run8(1'b0, 1'b0, nvalid, ones0, ones1, done_at, bad, cycles);
      check("r3_nvalid", nvalid, 255);
      check("r3_ones0", ones0, 64);
      check("r3_ones1", ones1, 255);
      check("r3_done_at", done_at, 255);
      check("r3_lfsr", 32'(b8.lfsr_out), 32'hFF);
      b8.threshold = {8'd0, 8'd128};
      b8.start = 1'b1;
      tick;
      check("b2b_busy", 32'(b8.busy), 1);
      run8(1'b0, 1'b0, nvalid, ones0, ones1, done_at, bad, cycles);
      check("b2b_nvalid", nvalid, 255);
      check("b2b_ones0", ones0, 128);

      // 4-bit, 3-channel instance: thr = 5 / 15 / 0.
      b4.threshold = {4'd0, 4'd15, 4'd5};
      b4.start = 1'b1;
      tick;
      b4.start = 1'b0;
      nvalid = 0; ones0 = 0; ones1 = 0; ones2 = 0; done_at = -1;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (b4.sn_valid) begin
            nvalid++;
            ones0 += int'(b4.sn_bit[0]);
            ones1 += int'(b4.sn_bit[1]);
            ones2 += int'(b4.sn_bit[2]);
         end
         if (b4.done) begin
            done_at = nvalid;
            break;
         end
      end
      check("w4_nvalid", nvalid, 15);
      check("w4_ones0", ones0, 5);
      check("w4_ones1", ones1, 15);
      check("w4_ones2", ones2, 0);
      check("w4_done_at", done_at, 15);
      check("w4_lfsr", 32'(b4.lfsr_out), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
